// File: rtl/traffic_timer.sv
// traffic_timer: timing engine for the traffic light controller.
// A clk-to-second prescaler drives a per-light countdown of remaining seconds.
// The FSM selects the next phase through one-hot light_cnt_init and watches
// second_cnt_pre_last / light_cnt_last to time its transitions.
//
// Ports:
//   clk                  in   rising-edge clock
//   rst                  in   synchronous active-high reset (priority over en)
//   en                   in   run enable; low holds the timer idle
//   light_cnt_init       in   one-hot next-phase select (0 green, 1 yellow, 2 red)
//   dur_green/yellow/red in   runtime phase durations (RUNTIME_DUR_EN only)
//   second_cnt_pre_last  out  en & prescaler one cycle before its wrap
//   light_cnt_last       out  remaining-seconds counter is at zero
//   sec_tick             out  en & prescaler at its wrap value
//   light_cnt            out  remaining seconds - 1
//
// Build option: define RUNTIME_DUR_EN to take phase durations from the
// dur_* inputs instead of the *_SEC parameters.
module traffic_timer #(
    parameter int unsigned CLK_PER_SEC       = 50_000_000,
    parameter int unsigned LIGHT_STATE_WIDTH = 3,
    parameter int unsigned SEC_W             = 8,
    parameter int unsigned GREEN_SEC         = 30,
    parameter int unsigned YELLOW_SEC        = 3,
    parameter int unsigned RED_SEC           = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
`ifdef RUNTIME_DUR_EN
    input  logic [SEC_W-1:0]             dur_green,
    input  logic [SEC_W-1:0]             dur_yellow,
    input  logic [SEC_W-1:0]             dur_red,
`endif
    output logic                         second_cnt_pre_last,
    output logic                         light_cnt_last,
    output logic                         sec_tick,
    output logic [SEC_W-1:0]             light_cnt
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_SEC);
    localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CLK_PER_SEC - 1);
    localparam logic [CNT_W-1:0] SEC_PRE  = CNT_W'(CLK_PER_SEC - 2);

    typedef enum logic [1:0] {
        SEL_GREEN  = 2'd0,
        SEL_YELLOW = 2'd1,
        SEL_RED    = 2'd2
    } sel_t;

    logic [CNT_W-1:0] sec_cnt, sec_cnt_nxt;
    logic [SEC_W-1:0] light_cnt_nxt;
    sel_t             sel, sel_nxt;
    logic [SEC_W-1:0] dur_g, dur_y, dur_r;
    logic [SEC_W-1:0] reload_green, reload_sel;

    // Phase durations, already truncated to SEC_W bits.
`ifdef RUNTIME_DUR_EN
    assign dur_g = dur_green;
    assign dur_y = dur_yellow;
    assign dur_r = dur_red;
`else
    assign dur_g = SEC_W'(GREEN_SEC);
    assign dur_y = SEC_W'(YELLOW_SEC);
    assign dur_r = SEC_W'(RED_SEC);
`endif

    // Reload value is duration-1, with a zero duration treated as one second.
    function automatic logic [SEC_W-1:0] reload_of(input logic [SEC_W-1:0] dur);
        return (dur == '0) ? '0 : dur - SEC_W'(1);
    endfunction

    // Reload for the currently selected phase.
    always_comb begin
        reload_green = reload_of(dur_g);
        case (sel)
            SEL_YELLOW: reload_sel = reload_of(dur_y);
            SEL_RED:    reload_sel = reload_of(dur_r);
            default:    reload_sel = reload_green;
        endcase
    end

    // Next-state: prescaler, phase countdown and phase select.
    always_comb begin
        sec_cnt_nxt   = '0;
        light_cnt_nxt = reload_green;
        sel_nxt       = SEL_GREEN;
        if (en) begin
            sec_cnt_nxt   = (sec_cnt == SEC_LAST) ? '0 : sec_cnt + CNT_W'(1);
            light_cnt_nxt = light_cnt;
            sel_nxt       = sel;
            // Tick edge: count down, reload from the sel held before this edge.
            if (sec_cnt == SEC_LAST) begin
                light_cnt_nxt = (light_cnt == '0) ? reload_sel : light_cnt - SEC_W'(1);
            end
            // Lowest set init bit wins.
            if (light_cnt_init[0]) begin
                sel_nxt = SEL_GREEN;
            end else if (light_cnt_init[1]) begin
                sel_nxt = SEL_YELLOW;
            end else if (light_cnt_init[2]) begin
                sel_nxt = SEL_RED;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt   <= '0;
            light_cnt <= reload_green;
            sel       <= SEL_GREEN;
        end else begin
            sec_cnt   <= sec_cnt_nxt;
            light_cnt <= light_cnt_nxt;
            sel       <= sel_nxt;
        end
    end

    // Status decodes returned to the FSM.
    assign second_cnt_pre_last = en & (sec_cnt == SEC_PRE);
    assign sec_tick            = en & (sec_cnt == SEC_LAST);
    assign light_cnt_last      = (light_cnt == '0);

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: two instances share stimulus.
//   dut1: CLK_PER_SEC=4, green 3 / yellow 1 / red 2, SEC_W=4
//   dut2: CLK_PER_SEC=2, green 17 / yellow 0 / red 20, SEC_W=4 (truncation, clamp)
// A seconds-level reference model predicts every output each cycle.
module tb_traffic_timer;

    localparam int unsigned SEC_W = 4;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [2:0] init;
    logic       pre1, tick1, last1, pre2, tick2, last2;
    logic [3:0] lc1, lc2;
    logic [6:0] obs1, obs2;

    int checks = 0;
    int errors = 0;

    // Reference model state: prescaler position, remaining seconds, selected phase.
    int cps [2] = '{4, 2};
    int durv[2][3] = '{'{3, 1, 2}, '{17, 0, 20}};
    int m_sec[2] = '{0, 0};
    int m_rem[2] = '{1, 1};
    int m_sel[2] = '{0, 0};

    always #5 clk = ~clk;

`ifdef RUNTIME_DUR_EN
    logic [3:0] d1g = 4'd3, d1y = 4'd1, d1r = 4'd2;
    logic [3:0] d2g = 4'd1, d2y = 4'd0, d2r = 4'd4;
`endif

    traffic_timer #(.CLK_PER_SEC(4), .LIGHT_STATE_WIDTH(3), .SEC_W(SEC_W),
                    .GREEN_SEC(3), .YELLOW_SEC(1), .RED_SEC(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .light_cnt_init(init),
`ifdef RUNTIME_DUR_EN
        .dur_green(d1g), .dur_yellow(d1y), .dur_red(d1r),
`endif
        .second_cnt_pre_last(pre1), .light_cnt_last(last1),
        .sec_tick(tick1), .light_cnt(lc1)
    );

    traffic_timer #(.CLK_PER_SEC(2), .LIGHT_STATE_WIDTH(3), .SEC_W(SEC_W),
                    .GREEN_SEC(17), .YELLOW_SEC(0), .RED_SEC(20)) dut2 (
        .clk(clk), .rst(rst), .en(en), .light_cnt_init(init),
`ifdef RUNTIME_DUR_EN
        .dur_green(d2g), .dur_yellow(d2y), .dur_red(d2r),
`endif
        .second_cnt_pre_last(pre2), .light_cnt_last(last2),
        .sec_tick(tick2), .light_cnt(lc2)
    );

    assign obs1 = {pre1, tick1, last1, lc1};
    assign obs2 = {pre2, tick2, last2, lc2};

    // Duration in whole seconds after SEC_W truncation, zero counted as one.
    function automatic int clampdur(input int raw);
        int d;
        d = raw % (1 << SEC_W);
        return (d == 0) ? 1 : d;
    endfunction

    // Predicted {pre_last, tick, last, light_cnt} for instance k under current inputs.
    function automatic logic [6:0] expv(input int k);
        logic p, t, l;
        p = en && (m_sec[k] == cps[k] - 2);
        t = en && (m_sec[k] == cps[k] - 1);
        l = (m_rem[k] == 1);
        return {p, t, l, 4'(m_rem[k] - 1)};
    endfunction

    // Advance the model across one clock edge with the inputs present at it.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst || !en) begin
                m_sec[k] = 0;
                m_rem[k] = clampdur(durv[k][0]);
                m_sel[k] = 0;
            end else begin
                if (m_sec[k] == cps[k] - 1) begin
                    m_sec[k] = 0;
                    if (m_rem[k] > 1) m_rem[k] = m_rem[k] - 1;
                    else              m_rem[k] = clampdur(durv[k][m_sel[k]]);
                end else begin
                    m_sec[k] = m_sec[k] + 1;
                end
                if (init[0])      m_sel[k] = 0;
                else if (init[1]) m_sel[k] = 1;
                else if (init[2]) m_sel[k] = 2;
            end
        end
    endtask

    // Apply inputs just after an edge and move to the sampling point.
    task automatic set_in(input logic r, input logic e, input logic [2:0] i);
        rst  = r;
        en   = e;
        init = i;
        @(negedge clk);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 3'b000);
        clock_edge();
        set_in(1'b1, 1'b0, 3'b000);
        clock_edge();
        set_in(1'b0, 1'b0, 3'b000);
        checks++;
        if (obs1 !== 7'b000_0010) begin
            errors++;
            $display("FAIL reset_dut1 got %b want %b", obs1, 7'b000_0010);
        end
        // dut2 green 17 truncates to 1 second: reload 0, last asserted.
        checks++;
        if (obs2 !== 7'b001_0000) begin
            errors++;
            $display("FAIL reset_dut2 got %b want %b", obs2, 7'b001_0000);
        end
        clock_edge();
    endtask

    task automatic test_phase_sequence();
        int lc_tab[17] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [2:0] i;
        logic [6:0] want;
        for (int c = 0; c < 17; c++) begin
            i = (c == 10) ? 3'b010 : (c == 14) ? 3'b100 : 3'b000;
            set_in(1'b0, 1'b1, i);
            want = {c % 4 == 2, c % 4 == 3, c >= 8 && c <= 15, 4'(lc_tab[c])};
            checks++;
            if (obs1 !== want) begin
                errors++;
                $display("FAIL phase_seq_dut1 cycle %0d got %b want %b", c, obs1, want);
            end
            checks++;
            if (obs2 !== expv(1)) begin
                errors++;
                $display("FAIL phase_seq_dut2 cycle %0d got %b want %b", c, obs2, expv(1));
            end
            clock_edge();
        end
    endtask

    task automatic test_en_drop();
        set_in(1'b0, 1'b0, 3'b000);
        clock_edge();
        for (int c = 0; c < 14; c++) begin
            set_in(1'b0, c != 5, 3'b000);
            if (c == 6) begin
                checks++;
                if (obs1 !== 7'b000_0010) begin
                    errors++;
                    $display("FAIL en_drop_idle got %b want %b", obs1, 7'b000_0010);
                end
            end
            if (c == 8 || c == 12) begin
                checks++;
                if (pre1 !== 1'b1) begin
                    errors++;
                    $display("FAIL en_drop_restart_pre cycle %0d got %b want 1", c, pre1);
                end
            end
            checks++;
            if (obs1 !== expv(0)) begin
                errors++;
                $display("FAIL en_drop_dut1 cycle %0d got %b want %b", c, obs1, expv(0));
            end
            clock_edge();
        end
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 16; c++) begin
            set_in(c == 9, 1'b1, 3'b000);
            if (c == 10) begin
                checks++;
                if (obs1 !== 7'b000_0010) begin
                    errors++;
                    $display("FAIL rst_mid_state got %b want %b", obs1, 7'b000_0010);
                end
            end
            if (c == 13) begin
                checks++;
                if (tick1 !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_tick got %b want 1", tick1);
                end
            end
            checks++;
            if (obs1 !== expv(0)) begin
                errors++;
                $display("FAIL rst_mid_dut1 cycle %0d got %b want %b", c, obs1, expv(0));
            end
            clock_edge();
        end
    endtask

    task automatic test_random();
        logic       r, e;
        logic [2:0] i;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 24) != 0);
            i = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            set_in(r, e, i);
            checks++;
            if (obs1 !== expv(0)) begin
                errors++;
                $display("FAIL random_dut1 cycle %0d got %b want %b", c, obs1, expv(0));
            end
            checks++;
            if (obs2 !== expv(1)) begin
                errors++;
                $display("FAIL random_dut2 cycle %0d got %b want %b", c, obs2, expv(1));
            end
            clock_edge();
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        init = 3'b000;
        test_reset();
        test_phase_sequence();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
